voice_frame_decoder: RTL and testbench

Receives the byte-serial control stream from the host MCU link and turns it into per-voice oscillator parameters: freq, cmds, envelopes, amplitude and shape. It sits between the byte receiver (SPI/UART front end) and the bank of oscillators, and is the writer for the parameters every oscillator reads. Frames are checksum-validated. A voice's parameters are committed atomically, so an oscillator never sees a half-written envelope.

---
 rtl/protocol_pkg.sv | 62 ++++++
 rtl/frame_byte_steer.sv | 46 ++++
 rtl/voice_frame_decoder.sv | 180 ++++++++++++++++++
 tb/tb_voice_frame_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/protocol_pkg.sv
// Shared types for the host control link: envelopes, wave shapes, frame decoder state,
// staged voice parameters and the byte-steering strobe.
package protocol_pkg;

  localparam int unsigned ENVELOPE_LEN       = 4;
  localparam int unsigned ENVELOPE_RESET_BIT = 7;

  typedef struct packed {
    logic [7:0] gain;
    logic [7:0] duration;
  } envelope_t;

  typedef enum logic [1:0] {
    SIN      = 2'd0,
    SQUARE   = 2'd1,
    SAW      = 2'd2,
    TRIANGLE = 2'd3
  } wave_shape;

  localparam logic [7:0]  FRAME_SYNC = 8'hA5;
  localparam int unsigned ENV_BYTES  = $bits(envelope_t) / 8;
  localparam int unsigned AMP_MAX_W  = 32;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    BODY   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } decoder_state_t;

  // Amplitude is held at the widest supported width; voices expose the low WIDTH bits.
  typedef struct packed {
    logic [15:0]                      freq;
    logic [7:0]                       cmds;
    wave_shape                        shape;
    logic [AMP_MAX_W-1:0]             amplitude;
    envelope_t [0:ENVELOPE_LEN-1]     envelopes;
  } voice_params_t;

  typedef enum logic [2:0] {
    FLD_NONE  = 3'd0,
    FLD_INDEX = 3'd1,
    FLD_CMDS  = 3'd2,
    FLD_FREQ  = 3'd3,
    FLD_SHAPE = 3'd4,
    FLD_AMP   = 3'd5,
    FLD_ENV   = 3'd6
  } stage_field_t;

  typedef struct packed {
    stage_field_t field;
    logic [7:0]   env_entry;
    logic [7:0]   env_byte;
    logic [7:0]   data;
  } steer_t;

  // Bytes on the wire including SYNC and checksum, for an amplitude of ab bytes.
  function automatic int unsigned frame_len(input int unsigned ab);
    return 7 + ab + ENVELOPE_LEN * ENV_BYTES;
  endfunction

endpackage

// File: rtl/frame_byte_steer.sv
// Maps a frame body byte position to the staging field it writes, including the
// envelope entry and byte-within-entry for envelope data.
module frame_byte_steer
  import protocol_pkg::*;
#(
  parameter int unsigned AB    = 3,
  parameter int unsigned CNT_W = 5
) (
  input  logic [CNT_W-1:0] byte_cnt,
  input  logic [7:0]       byte_data,
  output steer_t           strobe_c,
  output logic             last_c
);

  localparam int unsigned AMP_BASE = 5;
  localparam int unsigned ENV_BASE = AMP_BASE + AB;
  localparam int unsigned BODY_LEN = ENV_BASE + ENVELOPE_LEN * ENV_BYTES;

  logic [31:0] cnt_c;
  logic [31:0] rel_c;

  // Body layout: index, cmds, freq(2), shape, amplitude(AB), envelopes.
  always_comb begin
    cnt_c         = 32'(byte_cnt);
    rel_c         = cnt_c - ENV_BASE;
    strobe_c      = '0;
    strobe_c.data = byte_data;
    last_c        = (cnt_c == BODY_LEN - 1);
    if (cnt_c == 0) begin
      strobe_c.field = FLD_INDEX;
    end else if (cnt_c == 1) begin
      strobe_c.field = FLD_CMDS;
    end else if (cnt_c < 4) begin
      strobe_c.field = FLD_FREQ;
    end else if (cnt_c == 4) begin
      strobe_c.field = FLD_SHAPE;
    end else if (cnt_c < ENV_BASE) begin
      strobe_c.field = FLD_AMP;
    end else if (cnt_c < BODY_LEN) begin
      strobe_c.field     = FLD_ENV;
      strobe_c.env_entry = 8'(rel_c / ENV_BYTES);
      strobe_c.env_byte  = 8'(rel_c % ENV_BYTES);
    end
  end

endmodule

// File: rtl/voice_frame_decoder.sv
// Decodes checksum-protected host frames into per-voice oscillator parameters,
// committing a whole voice in one cycle from a separate staging copy.
module voice_frame_decoder
  import protocol_pkg::*;
#(
  parameter int unsigned N_VOICES = 8,
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned CMD_HOLD = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [15:0]      voice_freq      [N_VOICES],
  output logic [7:0]       voice_cmds      [N_VOICES],
  output envelope_t        voice_envelopes [N_VOICES][0:ENVELOPE_LEN-1],
  output logic [WIDTH-1:0] voice_amplitude [N_VOICES],
  output wave_shape        voice_shape     [N_VOICES],
  output logic             frame_done,
  output logic             frame_error
);

  localparam int unsigned AB       = (WIDTH + 7) / 8;
  localparam int unsigned BODY_LEN = frame_len(AB) - 2;
  localparam int unsigned CNT_W    = $clog2(BODY_LEN + 1);
  localparam int unsigned HOLD_W   = $clog2(CMD_HOLD + 2);
  localparam int unsigned IDLE_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned VIDX_W   = $clog2(N_VOICES);
  localparam int unsigned SHAPE_W  = $bits(wave_shape);

  decoder_state_t      state;
  logic [CNT_W-1:0]    byte_cnt;
  voice_params_t       stage;
  logic [7:0]          stage_index;
  logic [7:0]          xor_acc;
  logic [IDLE_W-1:0]   idle_cnt;
  voice_params_t       voice_q [N_VOICES];
  logic [HOLD_W-1:0]   hold_q  [N_VOICES];

  steer_t              strobe_c;
  logic                last_c;
  logic                accept_c;
  logic                timeout_c;
  logic                idx_ok_c;
  logic [VIDX_W-1:0]   vidx_c;
  logic                unused_amp_c;

  assign accept_c  = rx_valid && rx_ready;
  assign timeout_c = (idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign idx_ok_c  = (32'(stage_index) < N_VOICES);
  assign vidx_c    = stage_index[VIDX_W-1:0];

  frame_byte_steer #(
    .AB    (AB),
    .CNT_W (CNT_W)
  ) u_steer (
    .byte_cnt  (byte_cnt),
    .byte_data (rx_data),
    .strobe_c  (strobe_c),
    .last_c    (last_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      byte_cnt    <= '0;
      stage       <= '0;
      stage_index <= '0;
      xor_acc     <= '0;
      idle_cnt    <= '0;
      rx_ready    <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      for (int unsigned v = 0; v < N_VOICES; v++) begin
        voice_q[v] <= '0;
        hold_q[v]  <= '0;
      end
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      rx_ready    <= 1'b1;

      // Per-voice cmd hold; the last counted cycle clears the visible cmds.
      for (int unsigned v = 0; v < N_VOICES; v++) begin
        if (hold_q[v] != '0) begin
          hold_q[v] <= hold_q[v] - HOLD_W'(1);
          if (hold_q[v] == HOLD_W'(1)) voice_q[v].cmds <= '0;
        end
      end

      case (state)
        HUNT: begin
          if (accept_c && rx_data == FRAME_SYNC) begin
            state       <= BODY;
            byte_cnt    <= '0;
            stage       <= '0;
            stage_index <= '0;
            xor_acc     <= '0;
            idle_cnt    <= '0;
          end
        end

        BODY: begin
          if (accept_c) begin
            idle_cnt <= '0;
            xor_acc  <= xor_acc ^ rx_data;
            byte_cnt <= byte_cnt + CNT_W'(1);
            case (strobe_c.field)
              FLD_INDEX: stage_index     <= strobe_c.data;
              FLD_CMDS:  stage.cmds      <= strobe_c.data;
              FLD_FREQ:  stage.freq      <= {stage.freq[7:0], strobe_c.data};
              FLD_SHAPE: stage.shape     <= wave_shape'(strobe_c.data[SHAPE_W-1:0]);
              FLD_AMP:   stage.amplitude <= {stage.amplitude[AMP_MAX_W-9:0], strobe_c.data};
              FLD_ENV: begin
                for (int unsigned e = 0; e < ENVELOPE_LEN; e++) begin
                  for (int unsigned b = 0; b < ENV_BYTES; b++) begin
                    if (strobe_c.env_entry == 8'(e) && strobe_c.env_byte == 8'(b))
                      stage.envelopes[e][(ENV_BYTES-1-b)*8 +: 8] <= strobe_c.data;
                  end
                end
              end
              default: ;
            endcase
            if (last_c) state <= CHECK;
          end else if (timeout_c) begin
            frame_error <= 1'b1;
            state       <= HUNT;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end

        CHECK: begin
          if (accept_c) begin
            idle_cnt <= '0;
            if (rx_data == xor_acc && idx_ok_c) begin
              state    <= COMMIT;
              rx_ready <= 1'b0;
            end else begin
              frame_error <= 1'b1;
              state       <= HUNT;
            end
          end else if (timeout_c) begin
            frame_error <= 1'b1;
            state       <= HUNT;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end

        COMMIT: begin
          voice_q[vidx_c] <= stage;
          if (CMD_HOLD == 0) voice_q[vidx_c].cmds <= '0;
          hold_q[vidx_c]  <= HOLD_W'(CMD_HOLD);
          frame_done      <= 1'b1;
          state           <= HUNT;
        end

        default: state <= HUNT;
      endcase
    end
  end

  // Fan the committed voice registers out to the oscillator ports.
  always_comb begin
    unused_amp_c = 1'b0;
    for (int unsigned v = 0; v < N_VOICES; v++) begin
      voice_freq[v]      = voice_q[v].freq;
      voice_cmds[v]      = voice_q[v].cmds;
      voice_amplitude[v] = voice_q[v].amplitude[WIDTH-1:0];
      voice_shape[v]     = voice_q[v].shape;
      for (int unsigned e = 0; e < ENVELOPE_LEN; e++)
        voice_envelopes[v][e] = voice_q[v].envelopes[e];
      unused_amp_c = unused_amp_c ^ (^voice_q[v].amplitude);
    end
  end

endmodule

// File: tb/tb_voice_frame_decoder.sv
// Directed bench for voice_frame_decoder: commit timing, checksum/index errors,
// resync over garbage, inter-byte timeout boundary and mid-frame reset.
module tb_voice_frame_decoder;
  import protocol_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] voice_freq      [8];
  logic [7:0]  voice_cmds      [8];
  envelope_t   voice_envelopes [8][0:ENVELOPE_LEN-1];
  logic [23:0] voice_amplitude [8];
  wave_shape   voice_shape     [8];
  logic        frame_done;
  logic        frame_error;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  bit rand_gap  = 1'b0;
  logic [7:0] fr [18];

  always #5 clk = ~clk;

  voice_frame_decoder #(
    .N_VOICES (8),
    .WIDTH    (24),
    .CMD_HOLD (4),
    .TIMEOUT  (1024)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .voice_freq      (voice_freq),
    .voice_cmds      (voice_cmds),
    .voice_envelopes (voice_envelopes),
    .voice_amplitude (voice_amplitude),
    .voice_shape     (voice_shape),
    .frame_done      (frame_done),
    .frame_error     (frame_error)
  );

  always @(posedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_error) err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (rand_gap) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $error("FAIL rx_ready_wait observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic build(input logic [7:0] idx, input logic [7:0] cmds, input logic [15:0] freq,
                       input logic [7:0] shape, input logic [23:0] amp, input logic [7:0] g0);
    logic [7:0] x;
    fr[0] = 8'hA5;
    fr[1] = idx;
    fr[2] = cmds;
    fr[3] = freq[15:8];
    fr[4] = freq[7:0];
    fr[5] = shape;
    fr[6] = amp[23:16];
    fr[7] = amp[15:8];
    fr[8] = amp[7:0];
    for (int i = 0; i < 4; i++) begin
      fr[9 + 2*i]  = g0 + 8'(16 * i);
      fr[10 + 2*i] = 8'(i + 1);
    end
    x = 8'h00;
    for (int i = 1; i < 17; i++) x = x ^ fr[i];
    fr[17] = x;
  endtask

  task automatic send_range(input int from, input int to, input logic [7:0] mask);
    for (int i = from; i <= to; i++)
      send_byte((i == 17) ? (fr[i] ^ mask) : fr[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_error", frame_error, 0);
    chk("reset_freq3", voice_freq[3], 0);
    @(negedge clk) reset = 1'b0;
    idle(1);
    chk("ready_after_reset", rx_ready, 1);

    // Valid frame, voice 3.
    build(8'd3, 8'h01, 16'd440, 8'd0, 24'h7FFFFF, 8'h10);
    send_range(0, 17, 8'h00);
    chk("commit_cycle_done", frame_done, 0);
    chk("commit_cycle_ready", rx_ready, 0);
    idle(1);
    chk("v3_done", frame_done, 1);
    chk("v3_freq", voice_freq[3], 16'd440);
    chk("v3_amp", voice_amplitude[3], 24'h7FFFFF);
    chk("v3_shape", 64'(voice_shape[3]), 0);
    chk("v3_env0", 64'(voice_envelopes[3][0]), 64'h1001);
    chk("v3_env3", 64'(voice_envelopes[3][3]), 64'h4004);
    chk("v3_cmds_c1", voice_cmds[3], 8'h01);
    chk("v2_freq_untouched", voice_freq[2], 0);
    chk("v5_amp_untouched", voice_amplitude[5], 0);
    idle(1);
    chk("done_pulse_width", frame_done, 0);
    chk("v3_cmds_c2", voice_cmds[3], 8'h01);
    idle(1);
    chk("v3_cmds_c3", voice_cmds[3], 8'h01);
    idle(1);
    chk("v3_cmds_c4", voice_cmds[3], 8'h01);
    idle(1);
    chk("v3_cmds_cleared", voice_cmds[3], 8'h00);
    chk("v3_freq_kept", voice_freq[3], 16'd440);
    chk("done_count_1", done_cnt, 1);

    // Corrupted checksum, then an immediate valid frame.
    build(8'd3, 8'h02, 16'd1000, 8'd1, 24'h123456, 8'h20);
    send_range(0, 17, 8'hFF);
    chk("bad_csum_error", frame_error, 1);
    chk("bad_csum_ready", rx_ready, 1);
    idle(1);
    chk("error_pulse_width", frame_error, 0);
    chk("bad_csum_freq3", voice_freq[3], 16'd440);
    build(8'd1, 8'h04, 16'd1000, 8'd2, 24'h000102, 8'h30);
    send_range(0, 17, 8'h00);
    idle(1);
    chk("v1_done", frame_done, 1);
    chk("v1_freq", voice_freq[1], 16'd1000);
    chk("v1_shape", 64'(voice_shape[1]), 2);
    chk("v1_amp", voice_amplitude[1], 24'h000102);
    idle(2);
    chk("err_count_1", err_cnt, 1);
    chk("done_count_2", done_cnt, 2);

    // Leading garbage and 0xA5 within the body.
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'hA4);
    build(8'd6, 8'h80, 16'h00A5, 8'd3, 24'hA5A5A5, 8'hA5);
    send_range(0, 17, 8'h00);
    idle(1);
    chk("v6_done", frame_done, 1);
    chk("v6_freq", voice_freq[6], 16'h00A5);
    chk("v6_amp", voice_amplitude[6], 24'hA5A5A5);
    chk("v6_shape", 64'(voice_shape[6]), 3);
    chk("v6_env0", 64'(voice_envelopes[6][0]), 64'hA501);
    chk("v6_env1", 64'(voice_envelopes[6][1]), 64'hB502);
    idle(2);
    chk("err_count_still_1", err_cnt, 1);
    chk("done_count_3", done_cnt, 3);

    // Out-of-range voice index with a correct checksum.
    build(8'd9, 8'h01, 16'd777, 8'd0, 24'h111111, 8'h60);
    send_range(0, 17, 8'h00);
    chk("bad_index_error", frame_error, 1);
    idle(2);
    chk("bad_index_v1_kept", voice_freq[1], 16'd1000);
    chk("err_count_2", err_cnt, 2);
    chk("done_count_still_3", done_cnt, 3);

    // Inter-byte timeout boundary.
    build(8'd2, 8'h01, 16'd500, 8'd0, 24'h010203, 8'h40);
    send_range(0, 4, 8'h00);
    repeat (1024) @(posedge clk);
    #1;
    chk("timeout_1024_error", frame_error, 1);
    idle(1);
    chk("err_count_3", err_cnt, 3);
    send_range(0, 4, 8'h00);
    repeat (1023) @(posedge clk);
    #1;
    chk("stall_1023_no_error", frame_error, 0);
    send_range(5, 17, 8'h00);
    idle(1);
    chk("stall_1023_done", frame_done, 1);
    chk("v2_freq", voice_freq[2], 16'd500);
    idle(2);
    chk("err_count_still_3", err_cnt, 3);
    chk("done_count_4", done_cnt, 4);

    // Reset mid-frame, then a full frame with random valid gaps.
    build(8'd4, 8'h08, 16'd2000, 8'd1, 24'hABCDEF, 8'h50);
    send_range(0, 5, 8'h00);
    @(negedge clk) reset = 1'b1;
    idle(1);
    chk("midreset_ready", rx_ready, 0);
    @(negedge clk) reset = 1'b0;
    idle(1);
    chk("midreset_freq3", voice_freq[3], 0);
    chk("midreset_freq1", voice_freq[1], 0);
    chk("midreset_error", frame_error, 0);
    idle(1);
    chk("midreset_no_err_pulse", err_cnt, 3);
    rand_gap = 1'b1;
    send_range(0, 17, 8'h00);
    idle(1);
    chk("v4_done", frame_done, 1);
    chk("v4_freq", voice_freq[4], 16'd2000);
    chk("v4_amp", voice_amplitude[4], 24'hABCDEF);
    chk("v4_env2", 64'(voice_envelopes[4][2]), 64'h7003);
    chk("v4_cmds", voice_cmds[4], 8'h08);
    chk("v4_freq3_zero", voice_freq[3], 0);
    idle(2);
    chk("final_err_count", err_cnt, 3);
    chk("final_done_count", done_cnt, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
